johnson_seq_ctrl: RTL and testbench

//  Sequencing controller for a reversible WIDTH-bit Johnson (twisted-ring) counter.

---
 rtl/johnson_pkg.sv | 21 ++
 rtl/johnson_shift.sv | 40 ++++
 rtl/johnson_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_johnson_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared encodings for the Johnson ring sequencing controller.
// States, command modes and direction codes.
package johnson_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    MD_HOLD   = 2'b00,
    MD_CONT   = 2'b01,
    MD_BURST  = 2'b10,
    MD_SINGLE = 2'b11
  } mode_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/johnson_shift.sv
// Reversible WIDTH-bit Johnson ring with step enable, clear and
// a flag telling whether the current value is a legal ring code.
module johnson_shift #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nxt,
  output logic             legal
);
  import johnson_pkg::*;

  logic [WIDTH-1:0] inv;
  logic             lo_run;
  logic             hi_run;

  assign nxt = (dir == DIR_DN) ? {~q[0], q[WIDTH-1:1]}
                               : {q[WIDTH-2:0], ~q[WIDTH-1]};

  // Legal codes are a run of ones at the LSB end or at the MSB end.
  assign inv    = ~q;
  assign lo_run = ((q & (q + WIDTH'(1))) == '0);
  assign hi_run = ((inv & (inv + WIDTH'(1))) == '0);
  assign legal  = lo_run | hi_run;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Sequencing controller for a reversible Johnson ring: start/stop
// commands, burst and single stepping, phase decode, wrap/err pulses.
module johnson_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int PH_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [CNT_W-1:0] steps,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signal,
  output logic [PH_W-1:0]  phase,
  output logic             wrap,
  output logic             err
);
  import johnson_pkg::*;

  localparam logic [PH_W:0] TWO_W = (PH_W+1)'(2*WIDTH);

  state_t           state, state_nx;
  mode_t            mode_q, mode_nx;
  mode_t            mode_in;
  logic             dir_q, dir_nx;
  logic [CNT_W-1:0] rem_q, rem_nx;
  logic             step;
  logic             legal;
  logic [WIDTH-1:0] nxt;
  logic [PH_W:0]    ones;
  logic             hi_half;
  logic             lo_half;

  assign mode_in = mode_t'(mode);

  johnson_shift #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk   (clk),
    .reset (reset),
    .en    (step),
    .dir   (dir_q),
    .clr   (~legal),
    .q     (signal),
    .nxt   (nxt),
    .legal (legal)
  );

  always_comb begin
    state_nx = state;
    mode_nx  = mode_q;
    dir_nx   = dir_q;
    rem_nx   = rem_q;
    step     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start && mode_in != MD_HOLD) begin
          mode_nx  = mode_in;
          dir_nx   = dir;
          rem_nx   = steps;
          state_nx = (mode_in == MD_BURST && steps == '0)
                   ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // Stop wins over a pending step; a bad code burns the cycle.
        if (stop) begin
          state_nx = ST_DONE;
        end else if (legal) begin
          step = 1'b1;
          unique case (mode_q)
            MD_BURST: begin
              rem_nx = rem_q - CNT_W'(1);
              if (rem_q == CNT_W'(1)) state_nx = ST_DONE;
            end
            MD_SINGLE: state_nx = ST_DONE;
            default: ;
          endcase
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      mode_q <= MD_HOLD;
      dir_q  <= DIR_UP;
      rem_q  <= '0;
      wrap   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      mode_q <= mode_nx;
      dir_q  <= dir_nx;
      rem_q  <= rem_nx;
      wrap   <= step && (nxt == '0);
      err    <= ~legal;
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + {{PH_W{1'b0}}, signal[i]};
    end
  end

  assign hi_half = legal & signal[WIDTH-1] & ~(&signal);
  assign lo_half = legal & ~hi_half;

  always_comb begin
    phase = '0;
    unique case (1'b1)
      hi_half: phase = PH_W'(TWO_W - ones);
      lo_half: phase = ones[PH_W-1:0];
      default: phase = '0;
    endcase
  end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Scoreboard bench for johnson_seq_ctrl: directed commands push
// expected output events; a negedge monitor pops and compares.
module tb_johnson_seq_ctrl;

  typedef struct packed {
    logic [3:0] sig;
    logic [2:0] ph;
    logic       done;
    logic       wrap;
    logic       err;
    logic [7:0] bcnt;
  } ev_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic       dir;
  logic [7:0] steps;
  logic       stop;
  logic       busy;
  logic       done;
  logic [3:0] signal;
  logic [2:0] phase;
  logic       wrap;
  logic       err;

  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;

  johnson_seq_ctrl #(
    .WIDTH (4),
    .CNT_W (8),
    .PH_W  (3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mode   (mode),
    .dir    (dir),
    .steps  (steps),
    .stop   (stop),
    .busy   (busy),
    .done   (done),
    .signal (signal),
    .phase  (phase),
    .wrap   (wrap),
    .err    (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push(input logic [3:0] s, input logic [2:0] p,
                      input logic d, input logic w, input logic e,
                      input logic [7:0] b);
    ev_t ev;
    ev.sig  = s;
    ev.ph   = p;
    ev.done = d;
    ev.wrap = w;
    ev.err  = e;
    ev.bcnt = b;
    exp_q.push_back(ev);
  endtask

  // Monitor: an event is a ring change or any pulse output.
  initial begin
    logic [3:0] prev;
    int         bcnt;
    ev_t        ex;
    prev = 4'b0000;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if ((signal !== prev) || done || wrap || err) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got sig=%b ph=%0d done=%b wrap=%b err=%b, expected no event",
                   signal, phase, done, wrap, err);
        end else begin
          ex = exp_q.pop_front();
          if (signal !== ex.sig || phase !== ex.ph || done !== ex.done ||
              wrap !== ex.wrap || err !== ex.err ||
              (ex.done && bcnt != int'(ex.bcnt))) begin
            errors++;
            $display("FAIL event: got sig=%b ph=%0d done=%b wrap=%b err=%b busy_cyc=%0d, expected sig=%b ph=%0d done=%b wrap=%b err=%b busy_cyc=%0d",
                     signal, phase, done, wrap, err, bcnt,
                     ex.sig, ex.ph, ex.done, ex.wrap, ex.err, ex.bcnt);
          end
        end
        if (done) bcnt = 0;
      end
      prev = signal;
      if (!reset) bcnt = 0;
      else if (busy) bcnt++;
    end
  end

  task automatic issue(input logic [1:0] m, input logic d,
                       input logic [7:0] n);
    @(posedge clk);
    #1;
    start = 1'b1;
    mode  = m;
    dir   = d;
    steps = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    start = 1'b0;
    mode  = 2'b00;
    dir   = 1'b0;
    steps = 8'd0;
    stop  = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #20 reset = 1'b1;

    // 1: idle after reset, held for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (signal !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: got sig=%b busy=%b done=%b, expected 0000 0 0",
                 signal, busy, done);
      end
    end
    idle(1);

    // start with hold mode is ignored
    issue(2'b00, 1'b0, 8'd4);
    idle(4);

    // 2: burst of 3 up; input changes mid-run have no effect
    push(4'b0001, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0);
    push(4'b0011, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0);
    push(4'b0111, 3'd3, 1'b1, 1'b0, 1'b0, 8'd3);
    issue(2'b10, 1'b0, 8'd3);
    dir   = 1'b1;
    mode  = 2'b01;
    steps = 8'd0;
    idle(6);

    push(4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    pulse_reset();
    idle(2);

    // 3: continuous down, 8 steps, then stop
    push(4'b1000, 3'd7, 1'b0, 1'b0, 1'b0, 8'd0);
    push(4'b1100, 3'd6, 1'b0, 1'b0, 1'b0, 8'd0);
    push(4'b1110, 3'd5, 1'b0, 1'b0, 1'b0, 8'd0);
    push(4'b1111, 3'd4, 1'b0, 1'b0, 1'b0, 8'd0);
    push(4'b0111, 3'd3, 1'b0, 1'b0, 1'b0, 8'd0);
    push(4'b0011, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0);
    push(4'b0001, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0);
    push(4'b0000, 3'd0, 1'b0, 1'b1, 1'b0, 8'd0);
    push(4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 8'd9);
    issue(2'b01, 1'b1, 8'd0);
    repeat (8) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    idle(3);

    // 4: continuous up, stop after 5 steps
    push(4'b0001, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0);
    push(4'b0011, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0);
    push(4'b0111, 3'd3, 1'b0, 1'b0, 1'b0, 8'd0);
    push(4'b1111, 3'd4, 1'b0, 1'b0, 1'b0, 8'd0);
    push(4'b1110, 3'd5, 1'b0, 1'b0, 1'b0, 8'd0);
    push(4'b1110, 3'd5, 1'b1, 1'b0, 1'b0, 8'd6);
    issue(2'b01, 1'b0, 8'd0);
    repeat (5) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    idle(4);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: got busy=%b done=%b, expected 0 0", busy, done);
    end

    // 5: illegal code deposited into the ring
    push(4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 8'd0);
    @(negedge clk);
    #1 dut.u_shift.q = 4'b0101;
    idle(3);

    // single step up
    push(4'b0001, 3'd1, 1'b1, 1'b0, 1'b0, 8'd1);
    issue(2'b11, 1'b0, 8'd0);
    idle(4);

    // 6: burst of zero, then reset during a burst
    push(4'b0001, 3'd1, 1'b1, 1'b0, 1'b0, 8'd0);
    issue(2'b10, 1'b0, 8'd0);
    idle(3);
    push(4'b0011, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0);
    push(4'b0111, 3'd3, 1'b0, 1'b0, 1'b0, 8'd0);
    push(4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    issue(2'b10, 1'b0, 8'd5);
    repeat (2) @(posedge clk);
    pulse_reset();
    @(negedge clk);
    checks++;
    if (signal !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_burst: got sig=%b busy=%b, expected 0000 0", signal, busy);
    end
    idle(10);

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d still pending, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
